// File: rtl/text_buffer_pkg.sv
// Shared definitions for the text_buffer character store: control codes and FSM states.
package text_buffer_pkg;

  localparam int CC_CR     = 'h0D;
  localparam int CC_LF     = 'h0A;
  localparam int CC_BS     = 'h08;
  localparam int CC_FF     = 'h0C;
  localparam int PRINT_MIN = 'h20;

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port cell store: synchronous write, registered read-before-write read port.
module text_buffer_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 7,
  parameter int AW    = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; the array itself is swept by the clear FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= RST_VAL;
    else        rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_buffer.sv
// Terminal-style writable character buffer with cursor, control codes and line wrap.
// Define TEXT_BUFFER_SCROLL_EN to scroll at the last row instead of wrapping to row 0.
module text_buffer
  import text_buffer_pkg::*;
#(
  parameter int ROWS   = 32,
  parameter int COLS   = 32,
  parameter int CHAR_W = 7,
  parameter int FILL   = 'h20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  output logic [CHAR_W-1:0]         rd_char,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [CHAR_W-1:0]         wr_char,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic                      busy
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int AW = $clog2(ROWS * COLS);

  localparam logic [CHAR_W-1:0] FILL_C   = CHAR_W'(FILL);
  localparam logic [CHAR_W-1:0] K_CR     = CHAR_W'(CC_CR);
  localparam logic [CHAR_W-1:0] K_LF     = CHAR_W'(CC_LF);
  localparam logic [CHAR_W-1:0] K_BS     = CHAR_W'(CC_BS);
  localparam logic [CHAR_W-1:0] K_FF     = CHAR_W'(CC_FF);
  localparam logic [CHAR_W-1:0] K_PMIN   = CHAR_W'(PRINT_MIN);
  localparam logic [RW:0]       ROWS_X   = (RW+1)'(ROWS);
  localparam logic [RW-1:0]     ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 1);
  localparam logic [AW-1:0]     COLS_A   = AW'(COLS);
  localparam logic [AW-1:0]     CELL_END = AW'(ROWS * COLS - 1);
  localparam logic [AW-1:0]     LINE_END = AW'(COLS - 1);

  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] r, input logic [RW-1:0] t);
    logic [RW:0] s;
    s = {1'b0, r} + {1'b0, t};
    if (s >= ROWS_X) s = s - ROWS_X;
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * COLS_A + AW'(c);
  endfunction

  state_t              state_reg;
  logic [AW-1:0]       cnt_reg;
  logic [RW-1:0]       row_reg;
  logic [CW-1:0]       col_reg;
  logic [RW-1:0]       top_reg;
  logic [RW-1:0]       clr_row_reg;
  logic                we_reg;
  logic [AW-1:0]       waddr_reg;
  logic [CHAR_W-1:0]   wdata_reg;

  logic acc, is_cr, is_lf, is_bs, is_ff, is_print, advance;

  always_comb begin
    acc      = wr_valid && (state_reg == IDLE);
    is_cr    = (wr_char == K_CR);
    is_lf    = (wr_char == K_LF);
    is_bs    = (wr_char == K_BS);
    is_ff    = (wr_char == K_FF);
    is_print = (wr_char >= K_PMIN);
    advance  = acc && (is_lf || (is_print && col_reg == COL_LAST));
  end

  // Writes are registered one cycle, so a cell lands in the array the edge after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= CLR_ALL;
      cnt_reg     <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      top_reg     <= '0;
      clr_row_reg <= '0;
      we_reg      <= 1'b0;
      waddr_reg   <= '0;
      wdata_reg   <= FILL_C;
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        CLR_ALL: begin
          we_reg    <= 1'b1;
          waddr_reg <= cnt_reg;
          wdata_reg <= FILL_C;
          if (cnt_reg == CELL_END) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        CLR_LINE: begin
          we_reg    <= 1'b1;
          waddr_reg <= cell_addr(clr_row_reg, cnt_reg[CW-1:0]);
          wdata_reg <= FILL_C;
          if (cnt_reg == LINE_END) begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        IDLE: begin
          if (acc) begin
            if (is_ff) begin
              row_reg   <= '0;
              col_reg   <= '0;
              top_reg   <= '0;
              cnt_reg   <= '0;
              state_reg <= CLR_ALL;
            end else if (is_cr || is_lf) begin
              col_reg <= '0;
            end else if (is_bs) begin
              if (col_reg != '0) col_reg <= col_reg - 1'b1;
            end else if (is_print) begin
              we_reg    <= 1'b1;
              waddr_reg <= cell_addr(phys_row(row_reg, top_reg), col_reg);
              wdata_reg <= wr_char;
              col_reg   <= (col_reg == COL_LAST) ? '0 : col_reg + 1'b1;
            end
            if (advance) begin
              if (row_reg != ROW_LAST) begin
                row_reg <= row_reg + 1'b1;
              end else begin
`ifdef TEXT_BUFFER_SCROLL_EN
                // The old top physical row becomes the new bottom line.
                top_reg     <= (top_reg == ROW_LAST) ? '0 : top_reg + 1'b1;
                clr_row_reg <= top_reg;
`else
                row_reg     <= '0;
                clr_row_reg <= '0;
`endif
                cnt_reg   <= '0;
                state_reg <= CLR_LINE;
              end
            end
          end
        end
        default: state_reg <= CLR_ALL;
      endcase
    end
  end

  assign wr_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign cur_row  = row_reg;
  assign cur_col  = col_reg;

  text_buffer_ram #(
    .DEPTH   (ROWS * COLS),
    .WIDTH   (CHAR_W),
    .AW      (AW),
    .RST_VAL (FILL_C)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_reg),
    .waddr (waddr_reg),
    .wdata (wdata_reg),
    .raddr (cell_addr(phys_row(rd_row, top_reg), rd_col)),
    .rdata (rd_char)
  );

endmodule
